// File: rtl/raybox_spi_pkg.sv
// Shared definitions for the Wishbone SPI frame master: register offsets,
// CTRL/STATUS bit positions, shifter state encoding and a byte-lane merge helper.
package raybox_spi_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_BUF    = 5'h10;

  localparam int CTRL_START     = 0;
  localparam int CTRL_TGT       = 1;
  localparam int CTRL_NBITS_LSB = 8;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } spi_state_t;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Emits one SPI mode-0 frame, MSB first, on either the register or vector channel.
// Holds the shadow shift register, the half-period/bit counters and the sticky done flag.
module spi_frame_shifter
  import raybox_spi_pkg::*;
#(
  parameter int MAX_BITS = 128,
  parameter int CLK_DIV  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                tgt,
  input  logic [7:0]          nbits_m1,
  input  logic [MAX_BITS-1:0] frame,
  input  logic                done_clr,
  output logic                busy,
  output logic                done,
  output logic                reg_csb,
  output logic                reg_sclk,
  output logic                reg_mosi,
  output logic                vec_csb,
  output logic                vec_sclk,
  output logic                vec_mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(MAX_BITS - 1);

  spi_state_t          state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    last_bit;
  logic                high_phase;
  logic [MAX_BITS-2:0] shadow;
  logic                tgt_q;
  logic                csb_q;
  logic                sclk_q;
  logic                mosi_q;

  // The bit on the wire lives in mosi_q; shadow holds only the bits still to come.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      last_bit   <= '0;
      high_phase <= 1'b0;
      shadow     <= '0;
      tgt_q      <= 1'b0;
      csb_q      <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (done_clr) done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shadow     <= frame[MAX_BITS-2:0];
            mosi_q     <= frame[MAX_BITS-1];
            tgt_q      <= tgt;
            last_bit   <= (32'(nbits_m1) >= MAX_BITS - 1) ? BIT_MAX : BIT_W'(nbits_m1);
            div_cnt    <= '0;
            bit_cnt    <= '0;
            high_phase <= 1'b0;
            csb_q      <= 1'b0;
            sclk_q     <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!high_phase) begin
              high_phase <= 1'b1;
              sclk_q     <= 1'b1;
            end else begin
              high_phase <= 1'b0;
              sclk_q     <= 1'b0;
              if (bit_cnt == last_bit) begin
                mosi_q <= 1'b0;
                state  <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                mosi_q  <= shadow[MAX_BITS-2];
                shadow  <= {shadow[MAX_BITS-3:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            csb_q   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tgt_q only changes while idle, when csb/sclk/mosi are already at idle levels.
  assign reg_csb  = tgt_q ? 1'b1 : csb_q;
  assign reg_sclk = tgt_q ? 1'b0 : sclk_q;
  assign reg_mosi = tgt_q ? 1'b0 : mosi_q;
  assign vec_csb  = tgt_q ? csb_q  : 1'b1;
  assign vec_sclk = tgt_q ? sclk_q : 1'b0;
  assign vec_mosi = tgt_q ? mosi_q : 1'b0;

endmodule

// File: rtl/wb_spi_frame_master.sv
// Wishbone slave letting the management CPU load a frame buffer and fire one SPI
// frame at the raybox-zero register or vector SPI port.
module wb_spi_frame_master
  import raybox_spi_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          MAX_BITS = 128,
  parameter int          CLK_DIV  = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        o_reg_csb,
  output logic        o_reg_sclk,
  output logic        o_reg_mosi,
  output logic        o_vec_csb,
  output logic        o_vec_sclk,
  output logic        o_vec_mosi,
  output logic        o_busy
);

  localparam int NWORDS = MAX_BITS / 32;

  logic [31:0]         frame_buf [NWORDS];
  logic [MAX_BITS-1:0] frame_flat;
  logic                ctrl_tgt;
  logic [7:0]          ctrl_nbits_m1;
  logic                load;
  logic                done_clr;
  logic                busy;
  logic                done;
  logic                req;
  logic                hit;
  logic [4:0]          offset;
  logic [31:0]         rd_data;
  logic                unused_adr_bits;

  assign req             = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign hit             = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign offset          = {wbs_adr_i[4:2], 2'b00};
  assign unused_adr_bits = ^wbs_adr_i[1:0];
  assign o_busy          = busy;

  // BUF[0] sits at the top so frame bit 0 is the MSB of the flattened vector.
  always_comb begin
    frame_flat = '0;
    for (int k = 0; k < NWORDS; k++) begin
      frame_flat[MAX_BITS-1-32*k -: 32] = frame_buf[k];
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      if (offset == OFF_CTRL) begin
        rd_data[CTRL_TGT]            = ctrl_tgt;
        rd_data[CTRL_NBITS_LSB +: 8] = ctrl_nbits_m1;
      end else if (offset == OFF_STATUS) begin
        rd_data[STATUS_BUSY] = busy;
        rd_data[STATUS_DONE] = done;
      end else begin
        for (int k = 0; k < NWORDS; k++) begin
          if (offset == OFF_BUF + 5'(4*k)) rd_data = frame_buf[k];
        end
      end
    end
  end

  // load and done_clr are registered pulses, so the frame starts the cycle after the ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      ctrl_tgt      <= 1'b0;
      ctrl_nbits_m1 <= '0;
      load          <= 1'b0;
      done_clr      <= 1'b0;
      for (int k = 0; k < NWORDS; k++) frame_buf[k] <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= '0;
      load      <= 1'b0;
      done_clr  <= 1'b0;
      if (req) begin
        if (!wbs_we_i) begin
          wbs_dat_o <= rd_data;
        end else if (hit) begin
          if (offset == OFF_CTRL) begin
            if (wbs_sel_i[0]) ctrl_tgt <= wbs_dat_i[CTRL_TGT];
            if (wbs_sel_i[1]) ctrl_nbits_m1 <= wbs_dat_i[CTRL_NBITS_LSB +: 8];
            if (wbs_sel_i[0] && wbs_dat_i[CTRL_START] && !busy && !load) load <= 1'b1;
          end else if (offset == OFF_STATUS) begin
            if (wbs_sel_i[0] && wbs_dat_i[STATUS_DONE]) done_clr <= 1'b1;
          end
          for (int k = 0; k < NWORDS; k++) begin
            if (offset == OFF_BUF + 5'(4*k))
              frame_buf[k] <= merge_bytes(frame_buf[k], wbs_dat_i, wbs_sel_i);
          end
        end
      end
    end
  end

  spi_frame_shifter #(
    .MAX_BITS (MAX_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_shifter (
    .clock    (wb_clk_i),
    .reset    (wb_rst_i),
    .load     (load),
    .tgt      (ctrl_tgt),
    .nbits_m1 (ctrl_nbits_m1),
    .frame    (frame_flat),
    .done_clr (done_clr),
    .busy     (busy),
    .done     (done),
    .reg_csb  (o_reg_csb),
    .reg_sclk (o_reg_sclk),
    .reg_mosi (o_reg_mosi),
    .vec_csb  (o_vec_csb),
    .vec_sclk (o_vec_sclk),
    .vec_mosi (o_vec_mosi)
  );

endmodule
